latch_bank_ctrl: RTL and testbench
==================================

# latch_bank_ctrl

Sequencing and arbitration controller for the shared gated D-latch storage bank. Up to `NREQ` requesters compete for write access to one `WIDTH`-bit latch bank. The controller grants one requester at a time in round-robin order. For each write it drives the latch data input and generates a level-sensitive enable pulse with guaranteed setup and hold margins, so no requester ever toggles `D` while `en` is high. It sits between the requesting blocks and the latch bank instance, and it is the only driver of the bank's `D` and `en`.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8).
- `WIDTH`, 8, latch bank data width.
- `OPEN_CYCLES`, 2, cycles `latch_en` is held high per write; values below 1 are treated as 1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  per-requester write request, level.
- `wdata`  in  NREQ*WIDTH  requester data; requester i occupies bits [i*WIDTH +: WIDTH].
- `latch_Q`  in  WIDTH  latch bank Q outputs, used for readback.
- `gnt`  out  NREQ  one-hot grant, held for the whole transaction.
- `done`  out  1  one-cycle pulse marking write completion.
- `busy`  out  1  high in every state except IDLE.
- `latch_D`  out  WIDTH  registered data to the latch bank `D`.
- `latch_en`  out  1  registered latch enable.
- `err`  out  1  readback mismatch flag, one cycle, coincident with `done`.

## Operation
- FSM states: IDLE → SETUP → OPEN → HOLD → DONE → IDLE.
- **IDLE:**
  - If any `req` bit is set, select the winner i and move to SETUP.
  - Search order starts at `(last+1) mod NREQ`, where `last` is the most recently granted index; after reset the search starts at index 0.
  - On the transition edge: `gnt[i]` is set, `latch_D` ← `wdata[i]`, and `last` ← i.
- **SETUP:** one cycle with `latch_en`=0 and `latch_D` stable.
- **OPEN:** `latch_en`=1 for exactly `OPEN_CYCLES` cycles. An internal counter loads `OPEN_CYCLES-1` on entry and decrements each cycle; the state exits when the counter reaches 0.
- **HOLD:** one cycle with `latch_en`=0 and `latch_D` unchanged (hold margin).
- **DONE:**
  - `done`=1 for one cycle; `gnt` is still asserted during this cycle.
  - On exit, `gnt` clears and the FSM returns to IDLE.
- `latch_D` changes only on the IDLE→SETUP edge and holds its value at all other times, including in IDLE.
- Requester obligations: hold `req` and `wdata` stable from request until `done`.
  - Deasserting `req` mid-transaction does not abort the write; the transaction completes using the data captured at grant.
  - `wdata` changes after grant are ignored.
- Requests arriving while `busy` is high are not evaluated until the next IDLE.
- Simultaneous requests are resolved strictly by round-robin order; no requester is starved.

## Timing
- Reset value of every output: `gnt`=0, `done`=0, `busy`=0, `latch_D`=0, `latch_en`=0, `err`=0. FSM=IDLE, `last`=NREQ-1 (so the first search starts at 0).
- Reset mid-transaction: on the reset edge `latch_en` drops to 0 and all outputs return to reset values. The interrupted write is lost and `done` is not pulsed.
- Latency from `req` sampled in IDLE:
  - `gnt`/`busy`/`latch_D` appear the next cycle.
  - `latch_en` rises 2 cycles after the sampling edge.
  - `done` appears at cycle 3+`OPEN_CYCLES`.
- Transaction length: 3+`OPEN_CYCLES` cycles with `busy` high. Back-to-back writes have at least one IDLE cycle between them, so throughput is one write per 4+`OPEN_CYCLES` cycles.
- `latch_en` never rises in the same cycle that `latch_D` changes, and never falls in the same cycle that `latch_D` changes.

## Configuration
- Macro: `LATCH_BANK_READBACK_EN`.
- **Defined:**
  - In HOLD, compare `latch_Q` against `latch_D` and register the mismatch.
  - `err` pulses together with `done` if they differed.
  - `err` is cleared by reset and is otherwise 0.
- **Undefined:** no compare logic is built, `err` is tied to 0, and `latch_Q` is unused.

## Test plan
- Single requester, defaults: reset, then `req`=4'b0001 with `wdata[7:0]`=8'hA5. Required response:
  - `gnt`=0001 one cycle later and `latch_D`=8'hA5.
  - `latch_en` high for exactly 2 cycles, starting 2 cycles after the sampling edge.
  - `done` pulses at cycle 5 and `err`=0.
- All four requesting continuously with data 8'h11/22/33/44: grants arrive in order 0001, 0010, 0100, 1000, 0001. Each transaction is 5 busy cycles plus one IDLE, and `latch_D` follows that data sequence.
- Requester 2 drops `req` during OPEN: the write still completes with the captured data, `done` pulses, and the next search starts at index 3.
- `rst` asserted in the first OPEN cycle: the next cycle shows `latch_en`=0, `gnt`=0, `busy`=0, `latch_D`=0, and no `done`. A following `req`=4'b1000 is granted index 3; after reset the search starts at 0, and index 3 is the only requester.
- With `LATCH_BANK_READBACK_EN` defined and the bench forcing `latch_Q`=8'h00 while writing 8'hFF: `err`=1 in the `done` cycle. With the macro undefined, `err` stays 0 throughout.

Source files
------------

// File: rtl/latch_bank_ctrl.sv
// latch_bank_ctrl
// Round-robin write arbiter and enable sequencer for a shared gated D-latch
// bank. Each write runs IDLE -> SETUP -> OPEN -> HOLD -> DONE.
// SETUP and HOLD surround the enable pulse so that D is never moving while
// en is high.
// Optional feature macro: LATCH_BANK_READBACK_EN. When it is defined,
// latch_Q is compared against latch_D during HOLD, and err reports any
// mismatch in the DONE cycle.
module latch_bank_ctrl #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 8,
    parameter int OPEN_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    input  logic [WIDTH-1:0]        latch_Q,
    output logic [NREQ-1:0]         gnt,
    output logic                    done,
    output logic                    busy,
    output logic [WIDTH-1:0]        latch_D,
    output logic                    latch_en,
    output logic                    err
);

    localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int OC_EFF = (OPEN_CYCLES < 1) ? 1 : OPEN_CYCLES;
    localparam int CW     = (OC_EFF > 1) ? $clog2(OC_EFF) : 1;

    localparam logic [CW-1:0]   CNT_LOAD = CW'(OC_EFF - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [IW-1:0]   LAST_RST = IW'(NREQ - 1);
    localparam logic [NREQ-1:0] GNT_ONE  = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_OPEN  = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              en_q, en_d;
    logic              err_q, err_d;

    logic              found_s;
    logic [IW-1:0]     winner_s;
    logic [WIDTH-1:0]  sel_data_s;

    // Round-robin search starting one past the most recently granted index
    always_comb begin : rr_search
        int idx_v;
        found_s  = 1'b0;
        winner_s = '0;
        idx_v    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx_v = (int'(last_q) + 1 + k) % NREQ;
            if (!found_s && req[idx_v[IW-1:0]]) begin
                found_s  = 1'b1;
                winner_s = IW'(idx_v);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Pick the winning requester's data word
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner_s == IW'(i)) begin
                sel_data_s = wdata[i*WIDTH +: WIDTH];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Next-state, grant, data capture and registered-output decode
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (found_s) begin
                    state_d = S_SETUP;
                    gnt_d   = GNT_ONE << winner_s;
                    data_d  = sel_data_s;
                    last_d  = winner_s;
                end else begin
                    gnt_d   = '0;
                end
            end
            S_SETUP: begin
                state_d = S_OPEN;
                cnt_d   = CNT_LOAD;
            end
            S_OPEN: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            S_HOLD: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
        // Outputs are decoded from the state being entered so they register
        // in step with it.
        busy_d = (state_d != S_IDLE);
        en_d   = (state_d == S_OPEN);
        done_d = (state_d == S_DONE);
    end

`ifdef LATCH_BANK_READBACK_EN
    // Compare the bank against the driven data during HOLD; flag appears with done
    always_comb begin
        if (state_q == S_HOLD) begin
            err_d = (latch_Q != data_q);
        end else begin
            err_d = 1'b0;
        end
    end
`else
    logic unused_latch_q_s;
    assign unused_latch_q_s = ^latch_Q;

    // Readback is not built; err stays low
    always_comb begin
        err_d = 1'b0;
    end
`endif

    // State and output registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            en_q    <= en_d;
            err_q   <= err_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign latch_D  = data_q;
    assign latch_en = en_q;
    assign err      = err_q;

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Testbench for latch_bank_ctrl with default parameters.
// Table of per-cycle vectors plus hand-written round-robin and drop-request
// sequences.
module tb_latch_bank_ctrl;

`ifdef LATCH_BANK_READBACK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [7:0]  latch_Q;
    logic [3:0]  gnt;
    logic        done, busy, latch_en, err;
    logic [7:0]  latch_D;
    logic        qz;

    int n_vec  = 0;
    int n_miss = 0;

    // The bank model returns the driven data unless the bench forces zero
    assign latch_Q = qz ? 8'h00 : latch_D;

    latch_bank_ctrl #(.NREQ(4), .WIDTH(8), .OPEN_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata), .latch_Q(latch_Q),
        .gnt(gnt), .done(done), .busy(busy), .latch_D(latch_D),
        .latch_en(latch_en), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] wd;
        logic        qz;
        logic [3:0]  gnt;
        logic        done;
        logic        busy;
        logic [7:0]  d;
        logic        en;
        logic        err;
    } vec_t;

    vec_t vt[24];

    function automatic vec_t mk(logic r, logic [3:0] rq, logic [31:0] w, logic z,
                                logic [3:0] g, logic dn, logic b, logic [7:0] d,
                                logic e, logic er);
        vec_t v;
        v.rst = r; v.req = rq; v.wd = w; v.qz = z;
        v.gnt = g; v.done = dn; v.busy = b; v.d = d; v.en = e; v.err = er;
        return v;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic [7:0] rr_data [4];
    int wait_c, busy_c, done_seen;
    logic [7:0] d_at_done;
    logic [3:0] g_at_done;

    initial begin
        // rst req wdata qz | gnt done busy D en err
        vt[0]  = mk(1'b1, 4'h0, 32'h0000_0000, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        vt[1]  = mk(1'b1, 4'h0, 32'h0000_0000, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        vt[2]  = mk(1'b0, 4'h1, 32'h0000_00A5, 1'b0, 4'h1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        vt[3]  = mk(1'b0, 4'h1, 32'h0000_00A5, 1'b0, 4'h1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
        vt[4]  = mk(1'b0, 4'h1, 32'h0000_00A5, 1'b0, 4'h1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
        vt[5]  = mk(1'b0, 4'h1, 32'h0000_00A5, 1'b0, 4'h1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        vt[6]  = mk(1'b0, 4'h0, 32'h0000_00A5, 1'b0, 4'h1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
        vt[7]  = mk(1'b0, 4'h0, 32'h0000_00A5, 1'b0, 4'h0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0);
        vt[8]  = mk(1'b0, 4'h0, 32'h0000_0000, 1'b0, 4'h0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0);
        vt[9]  = mk(1'b0, 4'h2, 32'h0000_FF00, 1'b1, 4'h2, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        vt[10] = mk(1'b0, 4'h2, 32'h0000_FF00, 1'b1, 4'h2, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
        vt[11] = mk(1'b0, 4'h2, 32'h0000_FF00, 1'b1, 4'h2, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
        vt[12] = mk(1'b0, 4'h2, 32'h0000_FF00, 1'b1, 4'h2, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        vt[13] = mk(1'b0, 4'h0, 32'h0000_FF00, 1'b1, 4'h2, 1'b1, 1'b1, 8'hFF, 1'b0, ERR_EXP);
        vt[14] = mk(1'b0, 4'h0, 32'h0000_0000, 1'b0, 4'h0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
        vt[15] = mk(1'b0, 4'h4, 32'h0033_0000, 1'b0, 4'h4, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
        vt[16] = mk(1'b0, 4'h4, 32'h0033_0000, 1'b0, 4'h4, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0);
        vt[17] = mk(1'b1, 4'h4, 32'h0033_0000, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        vt[18] = mk(1'b0, 4'h8, 32'h4400_0000, 1'b0, 4'h8, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0);
        vt[19] = mk(1'b0, 4'h8, 32'h4400_0000, 1'b0, 4'h8, 1'b0, 1'b1, 8'h44, 1'b1, 1'b0);
        vt[20] = mk(1'b0, 4'h8, 32'h4400_0000, 1'b0, 4'h8, 1'b0, 1'b1, 8'h44, 1'b1, 1'b0);
        vt[21] = mk(1'b0, 4'h8, 32'h4400_0000, 1'b0, 4'h8, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0);
        vt[22] = mk(1'b0, 4'h0, 32'h4400_0000, 1'b0, 4'h8, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0);
        vt[23] = mk(1'b0, 4'h0, 32'h4400_0000, 1'b0, 4'h0, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0);

        rst = 1'b1; req = 4'h0; wdata = 32'h0; qz = 1'b0;
        #1;

        for (int i = 0; i < 24; i++) begin
            rst = vt[i].rst; req = vt[i].req; wdata = vt[i].wd; qz = vt[i].qz;
            step();
            chk($sformatf("vec%0d", i),
                {16'h0, gnt, done, busy, latch_D, latch_en, err},
                {16'h0, vt[i].gnt, vt[i].done, vt[i].busy, vt[i].d, vt[i].en, vt[i].err});
        end

        // All four requesting continuously: strict round-robin from index 0
        rr_data[0] = 8'h11; rr_data[1] = 8'h22; rr_data[2] = 8'h33; rr_data[3] = 8'h44;
        req = 4'hF; wdata = 32'h4433_2211;
        for (int t = 0; t < 5; t++) begin
            wait_c = 0;
            while (gnt == 4'h0 && wait_c < 20) begin
                step();
                wait_c++;
            end
            chk($sformatf("rr%0d_wait", t), wait_c, 1);
            chk($sformatf("rr%0d_gnt", t), {28'h0, gnt}, {28'h0, 4'h1 << (t % 4)});
            chk($sformatf("rr%0d_data", t), {24'h0, latch_D}, {24'h0, rr_data[t % 4]});
            busy_c = 0;
            while (busy && busy_c < 20) begin
                step();
                busy_c++;
            end
            chk($sformatf("rr%0d_busy_len", t), busy_c, 5);
        end
        req = 4'h0;

        // Requester 2 drops req and scrambles wdata in the first OPEN cycle
        req = 4'h4; wdata = 32'h0077_0000;
        step();
        chk("drop_gnt", {28'h0, gnt}, 32'h4);
        step();
        chk("drop_open", {31'h0, latch_en}, 32'h1);
        req = 4'h0; wdata = 32'h00EE_0000;
        done_seen = 0; wait_c = 0;
        d_at_done = 8'h00; g_at_done = 4'h0;
        while (done_seen == 0 && wait_c < 10) begin
            step();
            wait_c++;
            if (done) begin
                done_seen = 1;
                d_at_done = latch_D;
                g_at_done = gnt;
            end else begin
                done_seen = 0;
            end
        end
        chk("drop_done_latency", wait_c, 3);
        chk("drop_data", {24'h0, d_at_done}, 32'h77);
        chk("drop_gnt_at_done", {28'h0, g_at_done}, 32'h4);
        step();
        chk("drop_idle", {31'h0, busy}, 32'h0);

        // Next search begins at index 3, so 3 wins over 0
        req = 4'h9; wdata = 32'h9900_0088;
        step();
        chk("after_drop_gnt", {28'h0, gnt}, 32'h8);
        chk("after_drop_data", {24'h0, latch_D}, 32'h99);
        req = 4'h0;
        busy_c = 0;
        while (busy && busy_c < 20) begin
            step();
            busy_c++;
        end
        chk("after_drop_busy_len", busy_c, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
